// File: rtl/particle_streamer_pkg.sv
// Shared state encoding, particle payload layout and half-float field helpers
// for the particle streamer.
package particle_streamer_pkg;

  localparam int unsigned COORD_W     = 16;
  localparam int unsigned PARTICLE_W  = 3 * COORD_W;
  localparam int unsigned HF_SIGN_BIT = 15;
  localparam int unsigned HF_EXP_MSB  = 14;
  localparam int unsigned HF_EXP_LSB  = 10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_WAIT_READY = 3'd2,
    S_EMIT       = 3'd3,
    S_HOLD       = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } particle_t;

  // Behind the camera (negative z) or inf/NaN z are not worth rendering.
  function automatic logic hf_cull(input logic [COORD_W-1:0] z);
    return z[HF_SIGN_BIT] | (&z[HF_EXP_MSB:HF_EXP_LSB]);
  endfunction

endpackage

// File: rtl/particle_streamer.sv
// Streams one frame of particle positions from position memory to the render stage.
// Optional culling of negative / non-finite z is enabled with `define STREAMER_CULL_EN.
module particle_streamer
  import particle_streamer_pkg::*;
#(
  parameter int unsigned NUM_PARTICLES = 64,
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned MEM_LATENCY   = 2,
  parameter int unsigned HOLDOFF       = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic                  render_ready_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [47:0]           mem_data_in,
  output logic [15:0]           f_x_out,
  output logic [15:0]           f_y_out,
  output logic [15:0]           f_z_out,
  output logic                  data_valid_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [ADDR_WIDTH:0]   cull_count_out
);

  localparam int unsigned LAT_W  = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int unsigned HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_PARTICLES - 1);
  localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(MEM_LATENCY);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [ADDR_WIDTH-1:0] w_index_nxt;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [LAT_W-1:0]      w_lat_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [HOLD_W-1:0]     w_hold_nxt;
  particle_t             r_data;
  particle_t             w_data_nxt;
  particle_t             r_out;
  particle_t             w_out_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  particle_t             w_mem;
  logic                  w_last;
  logic                  w_cull_hit;

  assign w_mem  = particle_t'(mem_data_in);
  assign w_last = (r_index == LAST_IDX);

`ifdef STREAMER_CULL_EN
  logic [ADDR_WIDTH:0] r_cull_cnt;
  logic [ADDR_WIDTH:0] w_cull_nxt;
  assign w_cull_hit     = hf_cull(w_mem.z);
  assign cull_count_out = r_cull_cnt;
`else
  assign w_cull_hit     = 1'b0;
  assign cull_count_out = '0;
`endif

  assign mem_addr_out   = r_index;
  assign f_x_out        = r_out.x;
  assign f_y_out        = r_out.y;
  assign f_z_out        = r_out.z;
  assign data_valid_out = r_valid;
  assign busy_out       = r_busy;
  assign frame_done_out = r_done;

  // Next-state and next-register values; strobes are computed on the transition
  // into EMIT/DONE so their registers are high exactly during those states.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_lat_nxt   = r_lat_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_data_nxt  = r_data;
    w_out_nxt   = r_out;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef STREAMER_CULL_EN
    w_cull_nxt  = r_cull_cnt;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (frame_start_in) begin
          w_index_nxt = '0;
          w_lat_nxt   = '0;
          w_busy_nxt  = 1'b1;
`ifdef STREAMER_CULL_EN
          w_cull_nxt  = '0;
`endif
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_data_nxt = w_mem;
          w_lat_nxt  = '0;
          if (w_cull_hit) begin
`ifdef STREAMER_CULL_EN
            w_cull_nxt = r_cull_cnt + 1'b1;
`endif
            if (w_last) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_index_nxt = r_index + 1'b1;
              w_state_nxt = S_FETCH;
            end
          end else begin
            w_state_nxt = S_WAIT_READY;
          end
        end else begin
          w_lat_nxt = r_lat_cnt + 1'b1;
        end
      end

      S_WAIT_READY: begin
        if (render_ready_in) begin
          w_out_nxt   = r_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end

      S_EMIT: begin
        w_hold_nxt  = '0;
        w_state_nxt = S_HOLD;
      end

      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          if (w_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_index_nxt = r_index + 1'b1;
            w_lat_nxt   = '0;
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end

      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_lat_cnt  <= '0;
      r_hold_cnt <= '0;
      r_data     <= '0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef STREAMER_CULL_EN
      r_cull_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_lat_cnt  <= w_lat_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_data     <= w_data_nxt;
      r_out      <= w_out_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef STREAMER_CULL_EN
      r_cull_cnt <= w_cull_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_particle_streamer.sv
// Randomized self-checking bench for particle_streamer: a frame-level scoreboard
// predicts strobe contents, done/busy/cull behaviour, plus a few pinned timings.
module tb_particle_streamer;

  localparam int NP      = 4;
  localparam int AW      = 6;
  localparam int ML      = 2;
  localparam int HO      = 2;
  localparam int MIN_GAP = 1 + HO + ML + 1;
`ifdef STREAMER_CULL_EN
  localparam bit CULL_ON = 1'b1;
`else
  localparam bit CULL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] addr;
  logic [47:0]   mem_data;
  logic [15:0]   fx, fy, fz;
  logic          valid, busy, done;
  logic [AW:0]   cull;

  logic [AW-1:0] addr1;
  logic [15:0]   fx1, fy1, fz1;
  logic          valid1, busy1, done1;
  logic [AW:0]   cull1;
  localparam logic [47:0] ONE_DATA = 48'h3C00_4000_4200;

  always #5 clk = ~clk;

  particle_streamer #(.NUM_PARTICLES(NP), .ADDR_WIDTH(AW), .MEM_LATENCY(ML), .HOLDOFF(HO)) u_dut (
    .clk_in(clk), .rst_in(rst), .frame_start_in(start), .render_ready_in(ready),
    .mem_addr_out(addr), .mem_data_in(mem_data),
    .f_x_out(fx), .f_y_out(fy), .f_z_out(fz),
    .data_valid_out(valid), .busy_out(busy), .frame_done_out(done), .cull_count_out(cull)
  );

  particle_streamer #(.NUM_PARTICLES(1), .ADDR_WIDTH(AW), .MEM_LATENCY(ML), .HOLDOFF(HO)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .frame_start_in(start), .render_ready_in(ready),
    .mem_addr_out(addr1), .mem_data_in(ONE_DATA),
    .f_x_out(fx1), .f_y_out(fy1), .f_z_out(fz1),
    .data_valid_out(valid1), .busy_out(busy1), .frame_done_out(done1), .cull_count_out(cull1)
  );

  // Position memory with a two-cycle read pipeline.
  logic [47:0] mem [0:NP-1];
  logic [47:0] d1 = '0;
  logic [47:0] d2 = '0;
  always @(posedge clk) begin
    d1 <= mem[addr[1:0]];
    d2 <= d1;
  end
  assign mem_data = d2;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_cull(input logic [47:0] p);
`ifdef STREAMER_CULL_EN
    int z;
    z = int'(p[15:0]);
    return (z >= 32768) || (((z >> 10) & 31) == 31);
`else
    return 1'b0;
`endif
  endfunction

  // Frame-level model state.
  bit          m_busy = 0;
  bit          m_drop = 0;
  int          q[$];
  logic [47:0] m_last = '0;
  int          m_cull_frame = 0;
  int          m_cull_hold = 0;
  bit          prev_ready = 0;
  int          cyc = 0;
  int          since_strobe = 1000;
  int          frame_strobes = 0;
  int          strobes_total = 0;
  int          dones_total = 0;
  int          strobe_cyc[$];
  int          accept_cyc = 0;
  int          done_cyc = 0;
  int          s1_total = 0;
  int          dn1_total = 0;
  int          s1_cyc = 0;
  int          dn1_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_drop = 0; q.delete(); m_last = '0; m_cull_hold = 0; since_strobe = 1000;
      chk("reset_outputs", 64'({addr, fx, fy, fz, valid, busy, done, cull}), 64'd0);
    end else begin
      since_strobe++;
      if (valid) begin
        strobes_total++; frame_strobes++; strobe_cyc.push_back(cyc);
        chk("strobe_in_frame", 64'(m_busy), 64'd1);
        chk("strobe_after_ready", 64'(prev_ready), 64'd1);
        chk("holdoff_gap", 64'(since_strobe >= MIN_GAP), 64'd1);
        since_strobe = 0;
        if (q.size() == 0) begin
          chk("strobe_extra", 64'(frame_strobes), 64'd0);
        end else begin
          m_last = mem[q.pop_front()];
          chk("strobe_data", 64'({fx, fy, fz}), 64'(m_last));
        end
      end else begin
        chk("hold_data", 64'({fx, fy, fz}), 64'(m_last));
      end
      if (done) begin
        dones_total++; done_cyc = cyc;
        chk("done_in_frame", 64'(m_busy), 64'd1);
        chk("done_all_emitted", 64'(q.size()), 64'd0);
        chk("done_cull", 64'(cull), 64'(m_cull_frame));
        chk("busy_at_done", 64'(busy), 64'd1);
        m_drop = 1; m_cull_hold = m_cull_frame;
      end else if (m_drop) begin
        chk("busy_drop", 64'(busy), 64'd0);
        m_busy = 0; m_drop = 0;
      end else begin
        chk("busy", 64'(busy), 64'(m_busy));
      end
      if (!m_busy) chk("cull_hold", 64'(cull), 64'(m_cull_hold));
      if (start && !m_busy) begin
        m_busy = 1; q.delete(); m_cull_frame = 0; m_cull_hold = 0;
        for (int i = 0; i < NP; i++) begin
          if (is_cull(mem[i])) m_cull_frame++;
          else q.push_back(i);
        end
        since_strobe = 1000; frame_strobes = 0; accept_cyc = cyc;
      end
      if (valid1) begin s1_total++; s1_cyc = cyc; end
      if (done1) begin dn1_total++; dn1_cyc = cyc; end
    end
    prev_ready = ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input bit rnd);
    int n = 0;
    while ((m_busy || busy) && n < maxc) begin
      if (rnd) begin
        ready = ($urandom_range(0, 9) < 7);
        start = ($urandom_range(0, 99) < 3);
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("frame_timeout", 64'(n < maxc), 64'd1);
  endtask

  task automatic wait_strobes(input int target, input int maxc);
    int n = 0;
    while (strobes_total < target && n < maxc) begin
      tick();
      n++;
    end
    chk("strobe_timeout", 64'(n < maxc), 64'd1);
  endtask

  task automatic load_fixed();
    mem[0] = 48'h1111_2222_3333;
    mem[1] = 48'h4444_5555_0666;
    mem[2] = 48'h7777_0888_1999;
    mem[3] = 48'h0AAA_0BBB_2CCC;
  endtask

  int s0, d0;
  logic [15:0] rz;

  initial begin
    load_fixed();
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_reset_idle", 64'({addr, valid, busy, done, cull}), 64'd0);

    // Basic stream with pinned timing.
    ready = 1'b1;
    s0 = strobes_total; d0 = dones_total;
    strobe_cyc.delete();
    pulse_start();
    wait_idle(300, 1'b0);
    chk("basic_strobes", 64'(strobes_total - s0), 64'd4);
    chk("basic_dones", 64'(dones_total - d0), 64'd1);
    chk("basic_strobe_log", 64'(strobe_cyc.size()), 64'd4);
    if (strobe_cyc.size() == 4) begin
      chk("first_latency", 64'(strobe_cyc[0] - accept_cyc), 64'd5);
      for (int i = 1; i < 4; i++) chk("strobe_spacing", 64'(strobe_cyc[i] - strobe_cyc[i-1]), 64'd7);
      chk("done_latency", 64'(done_cyc - strobe_cyc[3]), 64'd3);
    end
    chk("basic_last_x", 64'(fx), 64'h0AAA);
    chk("basic_last_z", 64'(fz), 64'h2CCC);

    // Backpressure on particle 2.
    s0 = strobes_total;
    pulse_start();
    wait_strobes(s0 + 2, 200);
    ready = 1'b0;
    repeat (20) tick();
    chk("stall_no_strobe", 64'(strobes_total - s0), 64'd2);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_hold_x", 64'(fx), 64'h4444);
    ready = 1'b1;
    tick(); tick();
    chk("stall_release", 64'(strobes_total - s0), 64'd3);
    chk("stall_release_y", 64'(fy), 64'h0888);
    wait_idle(300, 1'b0);

    // Start pulsed mid-frame is ignored.
    d0 = dones_total;
    pulse_start();
    repeat (10) tick();
    pulse_start();
    wait_idle(300, 1'b0);
    repeat (5) tick();
    chk("busy_start_strobes", 64'(frame_strobes), 64'd4);
    chk("busy_start_dones", 64'(dones_total - d0), 64'd1);

    // Reset mid-frame.
    pulse_start();
    s0 = strobes_total;
    wait_strobes(s0 + 2, 200);
    tick();
    rst = 1'b1;
    #1;
    chk("async_reset", 64'({addr, fx, fy, fz, valid, busy, done, cull}), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    d0 = dones_total; s0 = strobes_total;
    repeat (20) tick();
    chk("reset_no_done", 64'(dones_total - d0), 64'd0);
    chk("reset_no_strobe", 64'(strobes_total - s0), 64'd0);
    chk("reset_idle", 64'(busy), 64'd0);
    strobe_cyc.delete();
    pulse_start();
    wait_idle(300, 1'b0);
    chk("restart_strobes", 64'(frame_strobes), 64'd4);

    // Cull candidate at index 1.
    mem[1] = 48'h1234_5678_C000;
    d0 = dones_total;
    pulse_start();
    wait_idle(300, 1'b0);
    tick();
    chk("cull_strobes", 64'(frame_strobes), CULL_ON ? 64'd3 : 64'd4);
    chk("cull_count", 64'(cull), CULL_ON ? 64'd1 : 64'd0);
    chk("cull_dones", 64'(dones_total - d0), 64'd1);
    load_fixed();

    // Single-particle instance.
    repeat (10) tick();
    s0 = s1_total; d0 = dn1_total;
    pulse_start();
    repeat (15) tick();
    chk("np1_strobes", 64'(s1_total - s0), 64'd1);
    chk("np1_dones", 64'(dn1_total - d0), 64'd1);
    chk("np1_done_latency", 64'(dn1_cyc - s1_cyc), 64'd3);
    chk("np1_data", 64'({fx1, fy1, fz1}), 64'(ONE_DATA));
    chk("np1_idle", 64'({addr1, busy1, valid1, done1, cull1}), 64'd0);
    wait_idle(300, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 3) == 0)
          rz = $urandom_range(0, 1) ? (16'h8000 | 16'($urandom)) : (16'h7C00 | 16'($urandom_range(0, 1023)));
        else
          rz = 16'($urandom_range(0, 16'h7BFF));
        mem[i] = {16'($urandom), 16'($urandom), rz};
      end
      repeat ($urandom_range(1, 4)) tick();
      pulse_start();
      wait_idle(3000, 1'b1);
      ready = 1'b0;
      tick();
    end

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
